uart_i2c_mode_seq: RTL and testbench
====================================

UART_I2C_MODE_SEQ -- requirements
Module: uart_i2c_mode_seq

Interface
REQ-001 Parameter GUARD_W, default 8, width of the guard-interval count.
REQ-002 Parameter DRAIN_W, default 16, width of the drain-timeout count.
REQ-003 app_clk  input  1  block clock; the block has one clock.
REQ-004 arst_n  input  1  reset, asynchronous and active-low.
REQ-005 mode_req  input  1  requested pad owner from the config register: 0 = UART, 1 = I2C.
REQ-006 uart_busy  input  1  UART TX/RX activity (FIFO non-empty or shifter active).
REQ-007 i2c_busy  input  1  I2C master transfer in progress or bus not idle.
REQ-008 guard_cycles  input  GUARD_W  pad-tristate interval length in app_clk cycles.
REQ-009 drain_limit  input  DRAIN_W  maximum drain wait in cycles; 0 disables the timeout.
REQ-010 uart_i2c_sel  output  1  pad/regbus mux select to the UART/I2C wrapper.
REQ-011 pad_hold  output  1  forces both shared pads tristated (oeb = 1) while high.
REQ-012 uart_srst_n  output  1  synchronous soft reset to the UART core, active-low.
REQ-013 i2c_srst_n  output  1  synchronous soft reset to the I2C master, active-low.
REQ-014 switch_busy  output  1  high whenever the FSM is not in ACTIVE.
REQ-015 switch_done  output  1  one-cycle pulse on completion of a switch.
REQ-016 drain_timeout  output  1  sticky flag set on a forced switch; cleared only by reset.

Function
REQ-017 The FSM SHALL have states ACTIVE, DRAIN, GUARD and SETTLE, all registered.
REQ-018 In ACTIVE, if mode_req != uart_i2c_sel, the FSM SHALL enter DRAIN on the next cycle; otherwise it SHALL remain in ACTIVE.
REQ-019 In DRAIN, the owner's busy signal SHALL be the one matching uart_i2c_sel: uart_busy when sel = 0, i2c_busy when sel = 1.
REQ-020 In DRAIN, if mode_req == uart_i2c_sel (request withdrawn), the FSM SHALL return to ACTIVE with no pad_hold, reset or done activity; withdrawal takes priority over busy and timeout.
REQ-021 In DRAIN, when the owner's busy signal is low, the FSM SHALL enter GUARD on the next cycle.
REQ-022 The drain counter SHALL clear on DRAIN entry and increment each DRAIN cycle.
REQ-023 When drain_limit != 0 and the count reaches drain_limit while busy is still high, the FSM SHALL enter GUARD and set drain_timeout.
REQ-024 In GUARD, pad_hold SHALL be 1 and the old owner's srst_n SHALL be 0.
REQ-025 GUARD SHALL last max(guard_cycles, 1) cycles; guard_cycles is sampled on GUARD entry.
REQ-026 On GUARD exit, uart_i2c_sel SHALL toggle and the FSM SHALL enter SETTLE.
REQ-027 SETTLE SHALL last exactly 2 cycles with pad_hold = 1 and the new owner's srst_n = 1.
REQ-028 On the transition SETTLE -> ACTIVE, the FSM SHALL pulse switch_done for one cycle and drive pad_hold to 0.
REQ-029 In ACTIVE, the non-selected block's srst_n SHALL be 0 and the selected block's srst_n SHALL be 1.
REQ-030 mode_req changes during GUARD or SETTLE SHALL be ignored; after ACTIVE is re-entered, a pending mismatch SHALL start a new switch.
REQ-031 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-032 Minimum switch latency, from a mode_req change to switch_done with busy low and guard_cycles <= 1, SHALL be 5 cycles.
REQ-033 Counters SHALL saturate and never wrap.

Reset
REQ-034 On arst_n low, the block SHALL reset to: state ACTIVE, uart_i2c_sel = 0, pad_hold = 0, uart_srst_n = 1, i2c_srst_n = 0, switch_busy = 0, switch_done = 0, drain_timeout = 0, counters 0.
REQ-035 Reset assertion mid-switch SHALL abort immediately to the reset values; no partial state survives.

Structure
REQ-036 State encoding and default parameter constants SHALL reside in the shared uart_i2c package, alongside the mode encoding (UART = 0, I2C = 1).
REQ-037 The block SHALL be a single module with no sub-modules; the wrapper gates the pad oeb lines with pad_hold and ANDs the core resets with srst_n.

Verification
REQ-038 Reset, then mode_req = 1 with both busy inputs 0 and guard_cycles = 0 -> switch_done at cycle 5, sel = 1, i2c_srst_n = 1, uart_srst_n = 0.
REQ-039 uart_busy high for 20 cycles after mode_req = 1, guard_cycles = 4 -> FSM stays in DRAIN 20 cycles, then pad_hold high 4 + 2 cycles, then switch_done; drain_timeout = 0.
REQ-040 uart_busy stuck at 1 with drain_limit = 10 -> GUARD entered after 10 DRAIN cycles, drain_timeout = 1 and remains 1 after the switch.
REQ-041 mode_req pulsed 1 for 3 cycles while uart_busy = 1 -> return to ACTIVE, sel = 0, no switch_done, pad_hold never asserted.
REQ-042 arst_n asserted during GUARD -> all outputs reach reset values asynchronously; a subsequent request completes a normal switch.
REQ-043 Back-to-back: mode_req 0 -> 1 -> 0 with the second change during SETTLE -> two switch_done pulses, final sel = 0.

Source files
------------

// File: rtl/uart_i2c_mode_seq_pkg.sv
// Shared encodings and default widths for the UART/I2C pad-owner sequencer.
package uart_i2c_mode_seq_pkg;

    // Pad owner encoding, also the encoding of mode_req and uart_i2c_sel.
    typedef enum logic {
        MODE_UART = 1'b0,
        MODE_I2C  = 1'b1
    } mode_e;

    // Switch sequencer states.
    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_GUARD  = 2'd2,
        ST_SETTLE = 2'd3
    } state_e;

    localparam int GUARD_W_DEF = 8;
    localparam int DRAIN_W_DEF = 16;

endpackage

// File: rtl/uart_i2c_mode_seq_if.sv
// Control bundle between the UART/I2C wrapper and the mode sequencer.
interface uart_i2c_mode_seq_if;
    logic mode_req;
    logic uart_busy;
    logic i2c_busy;
    logic uart_i2c_sel;
    logic pad_hold;
    logic uart_srst_n;
    logic i2c_srst_n;
    logic switch_busy;
    logic switch_done;
    logic drain_timeout;

    // Wrapper side: supplies the request and core activity, consumes the controls.
    modport master (
        output mode_req, uart_busy, i2c_busy,
        input  uart_i2c_sel, pad_hold, uart_srst_n, i2c_srst_n,
               switch_busy, switch_done, drain_timeout
    );

    // Sequencer side.
    modport slave (
        input  mode_req, uart_busy, i2c_busy,
        output uart_i2c_sel, pad_hold, uart_srst_n, i2c_srst_n,
               switch_busy, switch_done, drain_timeout
    );
endinterface

// File: rtl/uart_i2c_mode_seq.sv
// Hands the shared pads from one serial core to the other: drain the old
// owner, tristate the pads for a guard interval, flip the mux, let the new
// owner settle out of soft reset, then release the pads.
module uart_i2c_mode_seq
    import uart_i2c_mode_seq_pkg::*;
#(
    parameter int GUARD_W = GUARD_W_DEF,
    parameter int DRAIN_W = DRAIN_W_DEF
) (
    input  logic               app_clk,
    input  logic               arst_n,
    input  logic [GUARD_W-1:0] guard_cycles,
    input  logic [DRAIN_W-1:0] drain_limit,
    uart_i2c_mode_seq_if.slave bus
);

    state_e             state_q, state_d;
    logic               sel_q, sel_d;
    logic [GUARD_W-1:0] guard_cnt_q, guard_cnt_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic               settle_cnt_q, settle_cnt_d;
    logic               pad_hold_q, pad_hold_d;
    logic               uart_srst_n_q, uart_srst_n_d;
    logic               i2c_srst_n_q, i2c_srst_n_d;
    logic               switch_busy_q, switch_busy_d;
    logic               switch_done_q, switch_done_d;
    logic               drain_timeout_q, drain_timeout_d;

    logic               owner_busy;
    logic [DRAIN_W:0]   drain_inc;
    logic [DRAIN_W-1:0] drain_sat;
    logic               drain_expired;
    logic [GUARD_W-1:0] guard_load;

    // Next-state logic; every output is computed from the next state so it
    // leaves the block straight from a flop.
    always_comb begin
        state_d         = state_q;
        sel_d           = sel_q;
        guard_cnt_d     = guard_cnt_q;
        drain_cnt_d     = drain_cnt_q;
        settle_cnt_d    = settle_cnt_q;
        drain_timeout_d = drain_timeout_q;

        owner_busy    = sel_q ? bus.i2c_busy : bus.uart_busy;
        // One extra bit so the saturation point and the limit compare are exact.
        drain_inc     = {1'b0, drain_cnt_q} + (DRAIN_W+1)'(1);
        drain_sat     = drain_inc[DRAIN_W] ? drain_cnt_q : drain_inc[DRAIN_W-1:0];
        drain_expired = (drain_limit != '0) && (drain_inc >= {1'b0, drain_limit});
        // Guard lasts max(guard_cycles,1) cycles; the counter holds remaining-1.
        guard_load    = (guard_cycles == '0) ? '0 : guard_cycles - GUARD_W'(1);

        unique case (state_q)
            ST_ACTIVE: begin
                if (bus.mode_req != sel_q) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                drain_cnt_d = drain_sat;
                if (bus.mode_req == sel_q) begin
                    state_d = ST_ACTIVE;
                end else if (!owner_busy) begin
                    state_d     = ST_GUARD;
                    guard_cnt_d = guard_load;
                end else if (drain_expired) begin
                    state_d         = ST_GUARD;
                    guard_cnt_d     = guard_load;
                    drain_timeout_d = 1'b1;
                end
            end
            ST_GUARD: begin
                if (guard_cnt_q == '0) begin
                    state_d      = ST_SETTLE;
                    sel_d        = ~sel_q;
                    settle_cnt_d = 1'b0;
                end else begin
                    guard_cnt_d = guard_cnt_q - GUARD_W'(1);
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q) begin
                    state_d      = ST_ACTIVE;
                    settle_cnt_d = 1'b0;
                end else begin
                    settle_cnt_d = 1'b1;
                end
            end
            default: state_d = ST_ACTIVE;
        endcase

        pad_hold_d    = (state_d == ST_GUARD) || (state_d == ST_SETTLE);
        // Both cores are held in reset while the pads are in the guard gap.
        uart_srst_n_d = (state_d != ST_GUARD) && (sel_d == MODE_UART);
        i2c_srst_n_d  = (state_d != ST_GUARD) && (sel_d == MODE_I2C);
        switch_busy_d = (state_d != ST_ACTIVE);
        switch_done_d = (state_q == ST_SETTLE) && (state_d == ST_ACTIVE);
    end

    // State and output registers; reset drops any switch in flight.
    always_ff @(posedge app_clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q         <= ST_ACTIVE;
            sel_q           <= MODE_UART;
            guard_cnt_q     <= '0;
            drain_cnt_q     <= '0;
            settle_cnt_q    <= 1'b0;
            pad_hold_q      <= 1'b0;
            uart_srst_n_q   <= 1'b1;
            i2c_srst_n_q    <= 1'b0;
            switch_busy_q   <= 1'b0;
            switch_done_q   <= 1'b0;
            drain_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            sel_q           <= sel_d;
            guard_cnt_q     <= guard_cnt_d;
            drain_cnt_q     <= drain_cnt_d;
            settle_cnt_q    <= settle_cnt_d;
            pad_hold_q      <= pad_hold_d;
            uart_srst_n_q   <= uart_srst_n_d;
            i2c_srst_n_q    <= i2c_srst_n_d;
            switch_busy_q   <= switch_busy_d;
            switch_done_q   <= switch_done_d;
            drain_timeout_q <= drain_timeout_d;
        end
    end

    assign bus.uart_i2c_sel  = sel_q;
    assign bus.pad_hold      = pad_hold_q;
    assign bus.uart_srst_n   = uart_srst_n_q;
    assign bus.i2c_srst_n    = i2c_srst_n_q;
    assign bus.switch_busy   = switch_busy_q;
    assign bus.switch_done   = switch_done_q;
    assign bus.drain_timeout = drain_timeout_q;

endmodule

// File: tb/tb_uart_i2c_mode_seq.sv
// Directed bench for the UART/I2C pad-owner sequencer.
module tb_uart_i2c_mode_seq;

    logic        app_clk = 1'b0;
    logic        arst_n  = 1'b0;
    logic [7:0]  guard_cycles = '0;
    logic [15:0] drain_limit  = '0;

    int n_cmp = 0;
    int n_err = 0;

    uart_i2c_mode_seq_if bus();

    uart_i2c_mode_seq dut (
        .app_clk      (app_clk),
        .arst_n       (arst_n),
        .guard_cycles (guard_cycles),
        .drain_limit  (drain_limit),
        .bus          (bus)
    );

    always #5 app_clk = ~app_clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge app_clk);
        arst_n        = 1'b0;
        bus.mode_req  = 1'b0;
        bus.uart_busy = 1'b0;
        bus.i2c_busy  = 1'b0;
        guard_cycles  = '0;
        drain_limit   = '0;
        repeat (2) @(posedge app_clk);
        @(negedge app_clk);
        arst_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_sel"},   bus.uart_i2c_sel,  1'b0);
        chk1({tag, "_hold"},  bus.pad_hold,      1'b0);
        chk1({tag, "_usrst"}, bus.uart_srst_n,   1'b1);
        chk1({tag, "_isrst"}, bus.i2c_srst_n,    1'b0);
        chk1({tag, "_busy"},  bus.switch_busy,   1'b0);
        chk1({tag, "_done"},  bus.switch_done,   1'b0);
        chk1({tag, "_tmo"},   bus.drain_timeout, 1'b0);
    endtask

    // Request a switch and count cycles until switch_done (bounded).
    // Busy inputs drop after busy_len cycles; -1 keeps them as set.
    task automatic do_switch(input logic req, input int busy_len,
                             output int n_drain, output int n_hold,
                             output int n_cyc, output int n_done);
        n_drain = 0; n_hold = 0; n_cyc = 0; n_done = 0;
        bus.mode_req = req;
        for (int c = 0; c < 200; c++) begin
            @(posedge app_clk);
            #1;
            n_cyc++;
            if (n_cyc == busy_len) begin
                bus.uart_busy = 1'b0;
                bus.i2c_busy  = 1'b0;
            end
            if (bus.switch_busy && !bus.pad_hold) n_drain++;
            if (bus.pad_hold) n_hold++;
            if (bus.switch_done) begin
                n_done++;
                break;
            end
        end
    endtask

    initial begin
        int nd, nh, nc, dn;
        int d1, d2, dcnt, hcnt;
        bus.mode_req  = 1'b0;
        bus.uart_busy = 1'b0;
        bus.i2c_busy  = 1'b0;

        // Reset values.
        do_reset();
        #1;
        chk_reset_vals("rst");

        // Minimum-latency switch to I2C.
        guard_cycles = 8'd0;
        do_switch(1'b1, 0, nd, nh, nc, dn);
        chk("min_done",    dn, 1);
        chk("min_latency", nc, 5);
        chk("min_hold",    nh, 3);
        chk1("min_sel",    bus.uart_i2c_sel, 1'b1);
        chk1("min_isrst",  bus.i2c_srst_n,   1'b1);
        chk1("min_usrst",  bus.uart_srst_n,  1'b0);
        chk1("min_hold_end", bus.pad_hold,   1'b0);
        @(posedge app_clk); #1;
        chk1("min_pulse",  bus.switch_done,  1'b0);

        // Long drain then 4-cycle guard.
        do_reset();
        guard_cycles  = 8'd4;
        bus.uart_busy = 1'b1;
        do_switch(1'b1, 20, nd, nh, nc, dn);
        chk("drain_done",  dn, 1);
        chk("drain_cyc",   nd, 20);
        chk("drain_hold",  nh, 6);
        chk("drain_total", nc, 27);
        chk1("drain_tmo",  bus.drain_timeout, 1'b0);

        // Drain timeout with a stuck busy.
        do_reset();
        drain_limit   = 16'd10;
        bus.uart_busy = 1'b1;
        do_switch(1'b1, -1, nd, nh, nc, dn);
        chk("tmo_done",  dn, 1);
        chk("tmo_drain", nd, 10);
        chk("tmo_total", nc, 14);
        chk1("tmo_flag", bus.drain_timeout, 1'b1);
        chk1("tmo_sel",  bus.uart_i2c_sel,  1'b1);
        bus.uart_busy = 1'b0;
        repeat (3) @(posedge app_clk);
        #1;
        chk1("tmo_sticky", bus.drain_timeout, 1'b1);

        // Withdrawn request.
        do_reset();
        bus.uart_busy = 1'b1;
        bus.mode_req  = 1'b1;
        hcnt = 0; dcnt = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge app_clk);
            #1;
            if (bus.pad_hold) hcnt++;
            if (bus.switch_done) dcnt++;
            if (c == 2) chk1("wd_in_drain", bus.switch_busy, 1'b1);
            if (c == 3) bus.mode_req = 1'b0;
        end
        chk("wd_hold", hcnt, 0);
        chk("wd_done", dcnt, 0);
        chk1("wd_sel",   bus.uart_i2c_sel, 1'b0);
        chk1("wd_busy",  bus.switch_busy,  1'b0);
        chk1("wd_usrst", bus.uart_srst_n,  1'b1);

        // Reset during GUARD.
        do_reset();
        guard_cycles = 8'd8;
        bus.mode_req = 1'b1;
        repeat (3) @(posedge app_clk);
        #1;
        chk1("grd_hold",  bus.pad_hold,    1'b1);
        chk1("grd_usrst", bus.uart_srst_n, 1'b0);
        chk1("grd_isrst", bus.i2c_srst_n,  1'b0);
        #1 arst_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        #1 arst_n = 1'b1;
        guard_cycles = 8'd0;
        do_switch(1'b1, 0, nd, nh, nc, dn);
        chk("arst_redo_done", dn, 1);
        chk("arst_redo_cyc",  nc, 5);
        chk1("arst_redo_sel", bus.uart_i2c_sel, 1'b1);

        // Back-to-back with the second change landing in SETTLE.
        do_reset();
        bus.mode_req = 1'b1;
        d1 = 0; d2 = 0; dcnt = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge app_clk);
            #1;
            if (c == 3) begin
                chk1("b2b_settle_hold", bus.pad_hold,     1'b1);
                chk1("b2b_settle_sel",  bus.uart_i2c_sel, 1'b1);
                bus.mode_req = 1'b0;
            end
            if (bus.switch_done) begin
                dcnt++;
                if (dcnt == 1) d1 = c;
                if (dcnt == 2) d2 = c;
            end
        end
        chk("b2b_count", dcnt, 2);
        chk("b2b_first", d1, 5);
        chk("b2b_second", d2, 10);
        chk1("b2b_sel",   bus.uart_i2c_sel, 1'b0);
        chk1("b2b_usrst", bus.uart_srst_n,  1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
